// File: rtl/move_repeat_ctrl.sv
// move_repeat_ctrl: turns debounced direction/center button levels into
// one-cycle move requests (with hold-to-repeat) and one-cycle bomb requests.
// All outputs are registered; requests are suppressed while enable is low.
module move_repeat_ctrl #(
    parameter int unsigned REPEAT_DELAY = 50_000_000,
    parameter int unsigned REPEAT_RATE  = 20_000_000,
    parameter int unsigned CNT_W        = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_center,
    input  logic       enable,
    output logic       move_valid,
    output logic [1:0] move_dir,
    output logic       bomb_req
);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } state_t;

    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       act_dir_q, act_dir_d;
    logic             wr_q, wr_d;
    logic             center_q, center_d;
    logic             move_valid_q, move_valid_d;
    logic [1:0]       move_dir_q, move_dir_d;
    logic             bomb_req_q, bomb_req_d;

    logic [3:0]       dirs;
    logic [1:0]       pick_dir;
    logic             act_held;

    assign dirs     = {btn_right, btn_left, btn_down, btn_up};
    assign act_held = dirs[act_dir_q];

    // Fixed-priority direction select: up > down > left > right
    always_comb begin
        pick_dir = 2'd3;
        if (btn_up)        pick_dir = 2'd0;
        else if (btn_down) pick_dir = 2'd1;
        else if (btn_left) pick_dir = 2'd2;
    end

    // Next-state logic for the move FSM, release guard and bomb edge detect
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        act_dir_d    = act_dir_q;
        wr_d         = wr_q;
        move_valid_d = 1'b0;
        move_dir_d   = move_dir_q;
        center_d     = btn_center;
        bomb_req_d   = btn_center & ~center_q & enable;

        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            wr_d    = 1'b1;
        end else begin
            if (dirs == 4'b0000) wr_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (!wr_q && (dirs != 4'b0000)) begin
                        move_valid_d = 1'b1;
                        move_dir_d   = pick_dir;
                        act_dir_d    = pick_dir;
                        cnt_d        = '0;
                        state_d      = DELAY;
                    end
                end
                DELAY: begin
                    if (!act_held) begin
                        state_d = IDLE;
                    end else if (cnt_q == DELAY_LAST) begin
                        move_valid_d = 1'b1;
                        move_dir_d   = act_dir_q;
                        cnt_d        = '0;
                        state_d      = REPEAT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                REPEAT: begin
                    if (!act_held) begin
                        state_d = IDLE;
                    end else if (cnt_q == RATE_LAST) begin
                        move_valid_d = 1'b1;
                        move_dir_d   = act_dir_q;
                        cnt_d        = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            act_dir_q    <= '0;
            wr_q         <= 1'b1;
            center_q     <= 1'b1;
            move_valid_q <= 1'b0;
            move_dir_q   <= '0;
            bomb_req_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            act_dir_q    <= act_dir_d;
            wr_q         <= wr_d;
            center_q     <= center_d;
            move_valid_q <= move_valid_d;
            move_dir_q   <= move_dir_d;
            bomb_req_q   <= bomb_req_d;
        end
    end

    assign move_valid = move_valid_q;
    assign move_dir   = move_dir_q;
    assign bomb_req   = bomb_req_q;

endmodule

// File: tb/tb_move_repeat_ctrl.sv
// Testbench for move_repeat_ctrl: directed vector table, hand-written
// multi-cycle sequences and random stimulus against a hold-time model.
module tb_move_repeat_ctrl;

    localparam int RD = 8;
    localparam int RR = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_up, btn_down, btn_left, btn_right, btn_center;
    logic       enable;
    logic       move_valid;
    logic [1:0] move_dir;
    logic       bomb_req;

    int checks = 0;
    int errors = 0;

    move_repeat_ctrl #(
        .REPEAT_DELAY(RD),
        .REPEAT_RATE (RR),
        .CNT_W       (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_center(btn_center),
        .enable    (enable),
        .move_valid(move_valid),
        .move_dir  (move_dir),
        .bomb_req  (bomb_req)
    );

    always #5 clk = ~clk;

    // Reference model: tracks which direction is held and for how long
    int         m_held = -1;
    int         m_t = 0;
    bit         m_armed = 0;
    bit         m_prev = 1;
    bit         m_mv = 0;
    bit         m_bomb = 0;
    logic [1:0] m_dir = 2'd0;

    task automatic model_edge(input logic r, input logic e, input logic [4:0] b);
        if (r) begin
            m_held = -1; m_armed = 0; m_prev = 1;
            m_mv = 0; m_bomb = 0; m_dir = 2'd0;
        end else if (!e) begin
            m_held = -1; m_armed = 0;
            m_mv = 0; m_bomb = 0;
            m_prev = b[4];
        end else begin
            m_mv = 0;
            if (m_held >= 0) begin
                if (!b[m_held]) begin
                    m_held = -1;
                end else begin
                    m_t++;
                    if (m_t == RD || (m_t > RD && (m_t - RD) % RR == 0)) m_mv = 1;
                end
            end else if (m_armed && b[3:0] != 4'b0000) begin
                m_held = b[0] ? 0 : b[1] ? 1 : b[2] ? 2 : 3;
                m_t = 0;
                m_mv = 1;
                m_dir = 2'(m_held);
            end
            if (b[3:0] == 4'b0000) m_armed = 1;
            m_bomb = b[4] & ~m_prev;
            m_prev = b[4];
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // b = {center, right, left, down, up}
    task automatic step(input logic r, input logic e, input logic [4:0] b);
        rst = r;
        enable = e;
        {btn_center, btn_right, btn_left, btn_down, btn_up} = b;
        @(posedge clk);
        #1;
        model_edge(r, e, b);
        check("model_move_valid", int'(move_valid), int'(m_mv));
        check("model_move_dir", int'(move_dir), int'(m_dir));
        check("model_bomb_req", int'(bomb_req), int'(m_bomb));
    endtask

    typedef struct {
        logic       r;
        logic       e;
        logic [4:0] b;
        logic       mv;
        logic [1:0] dir;
        logic       bomb;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic e, input logic [4:0] b,
                       input logic mv, input logic [1:0] dir, input logic bomb);
        vec_t v;
        v.r = r; v.e = e; v.b = b; v.mv = mv; v.dir = dir; v.bomb = bomb;
        vecs.push_back(v);
    endtask

    logic [4:0] rb;
    logic       re, rr;

    initial begin
        rst = 1'b1; enable = 1'b1;
        {btn_center, btn_right, btn_left, btn_down, btn_up} = 5'b0;

        // Directed table: right held through reset, left+right together,
        // bomb edges with and without enable, priority
        add(1, 1, 5'b01000, 0, 2'd0, 0);
        add(1, 1, 5'b01000, 0, 2'd0, 0);
        add(0, 1, 5'b01000, 0, 2'd0, 0);
        add(0, 1, 5'b01000, 0, 2'd0, 0);
        add(0, 1, 5'b00000, 0, 2'd0, 0);
        add(0, 1, 5'b01000, 1, 2'd3, 0);
        add(0, 1, 5'b01000, 0, 2'd3, 0);
        add(0, 1, 5'b00000, 0, 2'd3, 0);
        add(0, 1, 5'b01100, 1, 2'd2, 0);
        add(0, 1, 5'b01100, 0, 2'd2, 0);
        add(0, 1, 5'b01100, 0, 2'd2, 0);
        add(0, 1, 5'b00000, 0, 2'd2, 0);
        add(0, 1, 5'b10000, 0, 2'd2, 1);
        add(0, 1, 5'b10000, 0, 2'd2, 0);
        add(0, 1, 5'b00000, 0, 2'd2, 0);
        add(0, 1, 5'b10000, 0, 2'd2, 1);
        add(0, 0, 5'b00000, 0, 2'd2, 0);
        add(0, 0, 5'b10000, 0, 2'd2, 0);
        add(0, 0, 5'b00000, 0, 2'd2, 0);
        add(0, 0, 5'b10000, 0, 2'd2, 0);
        add(0, 1, 5'b10000, 0, 2'd2, 0);
        add(0, 1, 5'b00000, 0, 2'd2, 0);
        add(0, 1, 5'b10001, 1, 2'd0, 1);
        add(0, 1, 5'b00001, 0, 2'd0, 0);
        add(0, 1, 5'b00000, 0, 2'd0, 0);
        add(0, 1, 5'b00110, 1, 2'd1, 0);
        add(0, 1, 5'b00000, 0, 2'd1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].r, vecs[i].e, vecs[i].b);
            check($sformatf("vec%0d_move_valid", i), int'(move_valid), int'(vecs[i].mv));
            check($sformatf("vec%0d_move_dir", i), int'(move_dir), int'(vecs[i].dir));
            check($sformatf("vec%0d_bomb_req", i), int'(bomb_req), int'(vecs[i].bomb));
        end

        // Hold-to-repeat: up held 30 cycles after reset
        step(1, 1, 5'b0);
        for (int i = 0; i < 10; i++) step(0, 1, 5'b0);
        for (int t = 0; t < 30; t++) begin
            step(0, 1, 5'b00001);
            check($sformatf("hold_up_t%0d", t), int'(move_valid),
                  (t == 0 || (t >= RD && (t - RD) % RR == 0)) ? 1 : 0);
        end
        for (int t = 0; t < 10; t++) begin
            step(0, 1, 5'b0);
            check("after_release", int'(move_valid), 0);
        end

        // Down held, left joins at 4, down released at 12
        for (int t = 0; t < 24; t++) begin
            step(0, 1, (t < 12 ? 5'b00010 : 5'b0) | (t >= 4 ? 5'b00100 : 5'b0));
            if (t == 0 || t == 8)
                check($sformatf("down_left_t%0d", t), int'({move_valid, move_dir}), 5);
            else if (t == 13 || t == 21)
                check($sformatf("down_left_t%0d", t), int'({move_valid, move_dir}), 6);
            else
                check($sformatf("down_left_t%0d", t), int'(move_valid), 0);
        end
        for (int t = 0; t < 3; t++) step(0, 1, 5'b0);

        // Enable dropped mid-count with up held
        for (int t = 0; t < 23; t++) begin
            step(0, (t == 6 || t == 7) ? 1'b0 : 1'b1, (t == 21) ? 5'b0 : 5'b00001);
            check($sformatf("en_drop_t%0d", t), int'(move_valid), (t == 0 || t == 22) ? 1 : 0);
        end
        for (int t = 0; t < 3; t++) step(0, 1, 5'b0);

        // Random stimulus against the model
        rb = 5'b0; re = 1'b1; rr = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            for (int k = 0; k < 4; k++)
                if ($urandom_range(0, 11) == 0) rb[k] = ~rb[k];
            if ($urandom_range(0, 3) == 0) rb[4] = ~rb[4];
            if (re) re = ($urandom_range(0, 79) != 0);
            else    re = ($urandom_range(0, 3) == 0);
            rr = ($urandom_range(0, 299) == 0);
            step(rr, re, rb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
